// File: rtl/mips_pkg.sv
// Shared types for the instruction-memory loader slice.
// Word type, loader state encoding and byte/word constants.
package mips_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    LOAD,
    CSUM,
    DONE,
    ERR
  } ld_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: 2-bit byte counter plus shift register.
// Ports: clk, rst, clr (restart at byte 0), take (byte accepted), data,
//        word_valid (pulse with the 4th byte), word (assembled word).
module byte_packer
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       take,
  input  logic [7:0] data,
  output logic       word_valid,
  output word_t      word
);

  localparam int CW = $clog2(BYTES_PER_WORD);
  localparam logic [CW-1:0] LAST = CW'(BYTES_PER_WORD - 1);
  localparam logic [CW-1:0] INC = CW'(1);

  logic [CW-1:0] cnt;
  logic [23:0]   acc;

  // The 4th byte completes the word combinationally so the owner can
  // register the write on the same edge the byte is accepted.
  assign word_valid = take && (cnt == LAST);
  assign word       = {acc, data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (clr) begin
      cnt <= '0;
      acc <= '0;
    end else if (take) begin
      cnt <= cnt + INC;
      acc <= {acc[15:0], data};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed big-endian byte stream in,
// sequential word writes out; holds the CPU until a valid program lands.
// Ports: clk, rst, start, in_data/in_valid/in_ready, mem_we/mem_addr/
//        mem_wdata, busy, done, error, cpu_hold, words_loaded.
// Option: IMEM_LOADER_CHECKSUM_EN adds a trailing 32-bit sum check.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [31:0] MAX_N = 32'(DEPTH - BASE_ADDR);
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  ld_state_t       state;
  logic [ADDR_W:0] len;
  logic [ADDR_W:0] wl_next;
  logic            take;
  logic            go;
  logic            pk_valid;
  word_t           pk_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  word_t           sum;
`endif

  assign take    = in_valid && in_ready;
  assign go      = start && (state == IDLE || state == DONE ||
                             state == ERR);
  assign wl_next = words_loaded + ONE;

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (go),
    .take       (take),
    .data       (in_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      len          <= '0;
      in_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      cpu_hold     <= 1'b1;
      words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (go) begin
            state        <= LEN;
            len          <= '0;
            in_ready     <= 1'b1;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum          <= '0;
`endif
          end
        end
        LEN: begin
          if (pk_valid) begin
            if (pk_word == '0) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else if (pk_word > MAX_N) begin
              state    <= ERR;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= LOAD;
              len   <= pk_word[ADDR_W:0];
            end
          end
        end
        LOAD: begin
          if (pk_valid) begin
            mem_we       <= 1'b1;
            mem_addr     <= BASE + words_loaded[ADDR_W-1:0];
            mem_wdata    <= pk_word;
            words_loaded <= wl_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum          <= sum + pk_word;
`endif
            // Stop taking bytes once the last word is in hand.
            if (wl_next == len) in_ready <= 1'b0;
          end else if (mem_we && words_loaded == len) begin
            // Leave LOAD only after the final strobe has been issued.
`ifdef IMEM_LOADER_CHECKSUM_EN
            state    <= CSUM;
            in_ready <= 1'b1;
`else
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: begin
          if (pk_valid) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (pk_word == sum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              error <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random loads compared
// against a stream-level model of the expected writes and final status.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int BASE   = 0;
  localparam int DEPTH  = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              error;
  logic              cpu_hold;
  logic [ADDR_W:0]   words_loaded;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          acc_cyc[$];
  int          w_cyc[$];
  int          w_addr[$];
  logic [31:0] w_data[$];
  logic [31:0] words[$];
  logic [7:0]  strm[$];

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cpu_hold     (cpu_hold),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle monitor: byte transfers and memory writes with cycle stamps.
  always @(negedge clk) begin
    if (in_valid && in_ready) acc_cyc.push_back(cyc);
    if (mem_we) begin
      w_cyc.push_back(cyc);
      w_addr.push_back(int'(mem_addr));
      w_data.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    acc_cyc.delete();
    w_cyc.delete();
    w_addr.delete();
    w_data.delete();
  endtask

  task automatic put_word(input logic [31:0] w);
    strm.push_back(w[31:24]);
    strm.push_back(w[23:16]);
    strm.push_back(w[15:8]);
    strm.push_back(w[7:0]);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (t < 100) begin
      @(negedge clk);
      if (in_ready) break;
      t++;
    end
    chk("ready_wait", t < 100, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_hold"}, cpu_hold, 1'b1);
    chk({tag, "_ready"}, in_ready, 1'b0);
    chk({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, error, 1'b0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_wl"}, words_loaded, 0);
  endtask

  // mode 0: back-to-back, 1: every-other-cycle plus a long mid-word gap
  // (with an ignored start pulse inside it), 2: random gaps.
  task automatic run_case(input string tag, input logic [31:0] nfield,
                          input int mode, input bit bad_csum);
    bit          len_ok;
    bit          exp_done;
    int          n_exp;
    int          t;
    int          lat;
    int          g;
    logic [31:0] sum;
    len_ok = (nfield != 0) && (nfield <= 32'(DEPTH - BASE));
    n_exp  = len_ok ? int'(nfield) : 0;
    strm.delete();
    put_word(nfield);
    sum = '0;
    for (int i = 0; i < n_exp; i++) begin
      put_word(words[i]);
      sum = sum + words[i];
    end
    exp_done = (nfield == 0) || len_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (len_ok) begin
      put_word(bad_csum ? sum + 32'd1 : sum);
      if (bad_csum) exp_done = 1'b0;
    end
`endif
    clear_mon();
    pulse_start();
    chk({tag, "_busy_on"}, busy, 1'b1);
    chk({tag, "_hold_on"}, cpu_hold, 1'b1);
    chk({tag, "_done_clr"}, done, 1'b0);
    for (int i = 0; i < strm.size(); i++) begin
      g = 0;
      if (mode == 1) begin
        g = i % 2;
        if (i == 9) begin
          start = 1'b1;
          @(posedge clk);
          #1 start = 1'b0;
          g = 10;
        end
      end else if (mode == 2) begin
        g = $urandom_range(0, 2);
      end
      push_byte(strm[i], g);
    end
    t = 0;
    while (!(done || error) && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_err"}, error, !exp_done);
    chk({tag, "_hold"}, cpu_hold, !exp_done);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_ready"}, in_ready, 1'b0);
    chk({tag, "_wl"}, words_loaded, n_exp);
    chk({tag, "_nwr"}, w_addr.size(), n_exp);
    for (int i = 0; i < n_exp && i < w_addr.size(); i++) begin
      lat = (4 * i + 7 < acc_cyc.size()) ? acc_cyc[4 * i + 7] + 1 : -1;
      chk({tag, "_waddr"}, w_addr[i], BASE + i);
      chk({tag, "_wdata"}, w_data[i], words[i]);
      chk({tag, "_wlat"}, w_cyc[i], lat);
    end
  endtask

  task automatic two_words();
    words.delete();
    words.push_back(32'h3C081234);
    words.push_back(32'h35085678);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("rst_held");
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst_idle");

    two_words();
    run_case("b2b", 32'd2, 0, 1'b0);

    words.delete();
    run_case("len257", 32'h101, 0, 1'b0);
    two_words();
    run_case("after_err", 32'd2, 0, 1'b0);

    two_words();
    run_case("gapped", 32'd2, 1, 1'b0);

    words.delete();
    run_case("len0", 32'd0, 0, 1'b0);

    // Reset after the 6th data byte: first word already written.
    clear_mon();
    two_words();
    strm.delete();
    put_word(32'd2);
    put_word(words[0]);
    put_word(words[1]);
    pulse_start();
    for (int i = 0; i < 10; i++) push_byte(strm[i], 0);
    rst = 1'b1;
    #1 check_reset_vals("rst_mid");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_nwr", w_addr.size(), 1);
    chk("rst_mid_w0", w_data.size() > 0 ? w_data[0] : 32'hx, words[0]);
    run_case("rst_mid_reload", 32'd2, 0, 1'b0);

    // Reset while the first write strobe is pending.
    clear_mon();
    pulse_start();
    for (int i = 0; i < 8; i++) push_byte(strm[i], 0);
    rst = 1'b1;
    #1 check_reset_vals("rst_we");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_we_nwr", w_addr.size(), 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    two_words();
    run_case("csum_ok", 32'd2, 0, 1'b0);
    two_words();
    run_case("csum_bad", 32'd2, 0, 1'b1);
`endif

    for (int k = 0; k < 5; k++) begin
      rand_words($urandom_range(1, 6));
      run_case("rand", 32'(words.size()), 2, 1'b0);
    end

    rand_words(DEPTH - BASE);
    run_case("full", 32'(DEPTH - BASE), 0, 1'b0);
    words.delete();
    run_case("len_max", 32'hFFFF_FFFF, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
